// File: rtl/nand_seq_ctrl.sv
// Sequenced logic evaluator: OR/AND/NOR/XOR built from one shared W-bit NAND,
// one NAND evaluation per clock edge, with a saturating evaluation counter.
module nand_seq_ctrl #(
    parameter int W = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [1:0]   OP,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         BUSY,
    output logic         DONE,
    output logic [W-1:0] X,
    output logic [7:0]   NCNT
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EVAL = 1'b1;

    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_NOR = 2'b10;

    localparam logic [1:0] DST_W1 = 2'd0;
    localparam logic [1:0] DST_W2 = 2'd1;
    localparam logic [1:0] DST_W3 = 2'd2;
    localparam logic [1:0] DST_X  = 2'd3;

    logic [0:0]   state_q, state_d;
    logic [1:0]   step_q, step_d;
    logic [1:0]   op_q, op_d;
    logic [W-1:0] a_q, a_d, b_q, b_d;
    logic [W-1:0] w1_q, w1_d, w2_q, w2_d, w3_q, w3_d;
    logic [W-1:0] x_q, x_d;
    logic         done_q, done_d;
    logic [7:0]   ncnt_q, ncnt_d;

    logic [W-1:0] nand_a, nand_b, nand_y;
    logic [1:0]   dest;
    logic         last;

    // Operand routing for the single NAND: which inputs and where the result lands.
    always_comb begin
        nand_a = a_q;
        nand_b = a_q;
        dest   = DST_W1;
        last   = 1'b0;
        case (op_q)
            OP_OR: begin
                case (step_q)
                    2'd0:    begin nand_a = a_q;  nand_b = a_q;  dest = DST_W1; end
                    2'd1:    begin nand_a = b_q;  nand_b = b_q;  dest = DST_W2; end
                    default: begin nand_a = w1_q; nand_b = w2_q; dest = DST_X; last = 1'b1; end
                endcase
            end
            OP_AND: begin
                case (step_q)
                    2'd0:    begin nand_a = a_q;  nand_b = b_q;  dest = DST_W1; end
                    default: begin nand_a = w1_q; nand_b = w1_q; dest = DST_X; last = 1'b1; end
                endcase
            end
            OP_NOR: begin
                case (step_q)
                    2'd0:    begin nand_a = a_q;  nand_b = a_q;  dest = DST_W1; end
                    2'd1:    begin nand_a = b_q;  nand_b = b_q;  dest = DST_W2; end
                    2'd2:    begin nand_a = w1_q; nand_b = w2_q; dest = DST_W3; end
                    default: begin nand_a = w3_q; nand_b = w3_q; dest = DST_X; last = 1'b1; end
                endcase
            end
            default: begin
                case (step_q)
                    2'd0:    begin nand_a = a_q;  nand_b = b_q;  dest = DST_W1; end
                    2'd1:    begin nand_a = a_q;  nand_b = w1_q; dest = DST_W2; end
                    2'd2:    begin nand_a = b_q;  nand_b = w1_q; dest = DST_W3; end
                    default: begin nand_a = w2_q; nand_b = w3_q; dest = DST_X; last = 1'b1; end
                endcase
            end
        endcase
    end

    assign nand_y = ~(nand_a & nand_b);

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        w3_d    = w3_q;
        x_d     = x_q;
        done_d  = 1'b0;
        ncnt_d  = ncnt_q;
        if (state_q == S_IDLE) begin
            if (START) begin
                op_d    = OP;
                a_d     = A;
                b_d     = B;
                step_d  = 2'd0;
                state_d = S_EVAL;
            end
        end else begin
            if (ncnt_q != 8'hFF) ncnt_d = ncnt_q + 8'd1;
            case (dest)
                DST_W1:  w1_d = nand_y;
                DST_W2:  w2_d = nand_y;
                DST_W3:  w3_d = nand_y;
                default: x_d  = nand_y;
            endcase
            if (last) begin
                done_d  = 1'b1;
                step_d  = 2'd0;
                state_d = S_IDLE;
            end else begin
                step_d = step_q + 2'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            step_q  <= 2'd0;
            op_q    <= 2'd0;
            a_q     <= '0;
            b_q     <= '0;
            w1_q    <= '0;
            w2_q    <= '0;
            w3_q    <= '0;
            x_q     <= '0;
            done_q  <= 1'b0;
            ncnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            w3_q    <= w3_d;
            x_q     <= x_d;
            done_q  <= done_d;
            ncnt_q  <= ncnt_d;
        end
    end

    assign BUSY = (state_q == S_EVAL);
    assign DONE = done_q;
    assign X    = x_q;
    assign NCNT = ncnt_q;
endmodule

// File: tb/tb_nand_seq_ctrl.sv
// Scoreboard bench for nand_seq_ctrl: a cycle-level reference model pushes
// expected completions; a monitor pops them on DONE and checks outputs each cycle.
module tb_nand_seq_ctrl;
    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         START = 1'b0;
    logic [1:0]   OP = 2'b00;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         BUSY, DONE;
    logic [W-1:0] X;
    logic [7:0]   NCNT;

    nand_seq_ctrl #(.W(W)) dut (
        .CLK(CLK), .RST(RST), .START(START), .OP(OP), .A(A), .B(B),
        .BUSY(BUSY), .DONE(DONE), .X(X), .NCNT(NCNT)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_x(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (op)
            2'b00:   return a | b;
            2'b01:   return a & b;
            2'b10:   return ~(a | b);
            default: return a ^ b;
        endcase
    endfunction

    function automatic int lat(input logic [1:0] op);
        case (op)
            2'b00:   return 3;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    // Reference model: abstract timeline of accepted requests
    typedef struct {
        logic [W-1:0] x;
        int           done_edge;
    } exp_t;
    exp_t q[$];

    int           edge_n = 0;
    int           busy_until = 0;
    bit           m_busy = 1'b0;
    int           m_cnt = 0;
    logic [W-1:0] m_x = '0;
    logic [W-1:0] pend_x = '0;

    always @(posedge CLK) begin
        edge_n++;
        if (RST) begin
            m_busy = 1'b0;
            m_cnt  = 0;
            m_x    = '0;
            q.delete();
        end else if (m_busy) begin
            m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
            if (edge_n == busy_until) begin
                m_busy = 1'b0;
                m_x    = pend_x;
            end
        end else if (START) begin
            m_busy     = 1'b1;
            busy_until = edge_n + lat(OP);
            pend_x     = ref_x(OP, A, B);
            q.push_back('{pend_x, busy_until});
        end
    end

    // Monitor
    always @(posedge CLK) begin
        exp_t e;
        #1;
        chk("busy", BUSY, m_busy);
        chk("ncnt", NCNT, m_cnt);
        chk("x_hold", X, m_x);
        if (q.size() > 0 && q[0].done_edge < edge_n) begin
            n_checks++;
            n_fail++;
            $display("FAIL missing_done: expected at edge %0d, now edge %0d", q[0].done_edge, edge_n);
            void'(q.pop_front());
        end
        if (DONE) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_done: got DONE at edge %0d, required none", edge_n);
            end else begin
                e = q.pop_front();
                chk("done_x", X, e.x);
                chk("done_edge", edge_n, e.done_edge);
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (BUSY && k < 20) begin
            @(negedge CLK);
            k++;
        end
        if (k >= 20) begin
            n_checks++;
            n_fail++;
            $display("FAIL busy_timeout: BUSY still %0b, required 0", BUSY);
        end
    endtask

    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge CLK);
        START = 1'b1; OP = op; A = a; B = b;
        @(negedge CLK);
        START = 1'b0;
        wait_idle();
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        chk("reset_x", X, 0);
        chk("reset_ncnt", NCNT, 0);
        chk("reset_busy", BUSY, 0);

        // OR
        do_op(2'b00, 4'b1010, 4'b0110);
        chk("or_x", X, 4'b1110);
        chk("or_ncnt", NCNT, 3);

        // XOR with operands toggled while busy
        @(negedge CLK);
        START = 1'b1; OP = 2'b11; A = 4'b1010; B = 4'b0110;
        @(negedge CLK);
        START = 1'b0; A = 4'b1111; B = 4'b1111; OP = 2'b00;
        wait_idle();
        chk("xor_x", X, 4'b1100);

        // Back-to-back AND then NOR with START held
        do_reset();
        START = 1'b1; OP = 2'b01; A = 4'b1100; B = 4'b1010;
        @(negedge CLK);
        OP = 2'b10;
        repeat (2) @(negedge CLK);
        chk("and_x", X, 4'b1000);
        chk("and_done", DONE, 1);
        @(negedge CLK);
        START = 1'b0;
        wait_idle();
        chk("nor_x", X, 4'b0001);
        chk("b2b_ncnt", NCNT, 6);

        // Reset at the 2nd EVAL edge of an OR
        @(negedge CLK);
        START = 1'b1; OP = 2'b00; A = 4'b1010; B = 4'b0110;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("abort_busy", BUSY, 0);
        chk("abort_x", X, 0);
        chk("abort_ncnt", NCNT, 0);
        repeat (3) @(negedge CLK);
        do_op(2'b00, 4'b1010, 4'b0110);
        chk("post_abort_or_x", X, 4'b1110);

        // Saturation: 70 XORs
        do_reset();
        for (int i = 0; i < 70; i++)
            do_op(2'b11, W'($urandom), W'($urandom));
        chk("sat_ncnt", NCNT, 255);
        do_op(2'b01, 4'b1111, 4'b0101);
        chk("sat_hold", NCNT, 255);
        do_reset();
        chk("sat_reset", NCNT, 0);

        // START held into EVAL of an AND is ignored
        @(negedge CLK);
        START = 1'b1; OP = 2'b01; A = 4'b0110; B = 4'b0011;
        repeat (2) @(negedge CLK);
        START = 1'b0;
        wait_idle();
        chk("ign_x", X, 4'b0010);
        chk("ign_ncnt", NCNT, 2);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            START = 1'($urandom_range(0, 1));
            OP    = 2'($urandom);
            A     = W'($urandom);
            B     = W'($urandom);
            RST   = ($urandom_range(0, 59) == 0);
        end
        @(negedge CLK);
        START = 1'b0; RST = 1'b0;
        repeat (8) @(negedge CLK);
        chk("drain_queue", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
